rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 102 ++++++++++
 tb/tb_rom_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Round-robin arbiter in front of a single synchronous ROM with fixed 1-cycle read latency.
// Define ROM_ARB_FIXED_PRIO_EN to swap round-robin for fixed priority (lowest index wins).
module rom_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int NREQ  = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rom_en,
  output logic [AW-1:0]        rom_addr,
  input  logic [WIDTH-1:0]     rom_data
);

  logic          gnt_any;
  logic [PW-1:0] gnt_idx;
  logic          tag_vld_q, tag_vld_d;
  logic [PW-1:0] tag_idx_q, tag_idx_d;
  logic          rsp_any;

`ifndef ROM_ARB_FIXED_PRIO_EN
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   rr_sum;
  logic [PW-1:0] rr_idx;
`endif

  // Grant selection: reset suppresses any grant so nothing is accepted while rst is high.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
`ifdef ROM_ARB_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(k);
      end
    end
`else
    rr_sum = '0;
    rr_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (rr_sum >= (PW+1)'(NREQ)) rr_sum = rr_sum - (PW+1)'(NREQ);
      rr_idx = rr_sum[PW-1:0];
      if (!gnt_any && req_valid[rr_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx;
      end
    end
`endif
    if (rst) gnt_any = 1'b0;
  end

  always_comb begin
    req_ready = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    rom_en    = gnt_any;
    rom_addr  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_any && gnt_idx == PW'(k)) rom_addr = req_addr[k*AW +: AW];
    end
  end

  always_comb begin
    tag_vld_d = gnt_any;
    tag_idx_d = gnt_any ? gnt_idx : tag_idx_q;
`ifndef ROM_ARB_FIXED_PRIO_EN
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
`endif
  end

  // Tag index is only meaningful while tag_vld_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      tag_vld_q <= tag_vld_d;
`ifndef ROM_ARB_FIXED_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
    tag_idx_q <= tag_idx_d;
  end

  // Response stage: a reset in the response cycle squashes the pulse.
  always_comb begin
    rsp_any   = tag_vld_q && !rst;
    rsp_valid = rsp_any ? (NREQ'(1) << tag_idx_q) : '0;
    rsp_data  = rsp_any ? rom_data : '0;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed table-driven bench for rom_arbiter (NREQ=4, DEPTH=8) with a ROM model mem[a] = 8'h10 + a.
module tb_rom_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int NREQ  = 4;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NREQ-1:0]  req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ-1:0]  rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rom_en;
  logic [AW-1:0]    rom_addr;
  logic [WIDTH-1:0] rom_data = '0;

  int errors = 0;
  int checks = 0;

  rom_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) rom_data <= 8'h10 + {5'b0, rom_addr};
  end

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [11:0] addr;
    logic [3:0]  rdy;
    logic        en;
    logic [2:0]  raddr;
    logic [3:0]  rv;
    logic [7:0]  rd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic [3:0] v, logic [11:0] a, logic [3:0] rdy,
                              logic en, logic [2:0] ra, logic [3:0] rv, logic [7:0] rd);
    vec_t t;
    t.rst = r; t.vld = v; t.addr = a; t.rdy = rdy;
    t.en = en; t.raddr = ra; t.rv = rv; t.rd = rd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [11:0] a);
    @(posedge clk);
    #1;
    rst = r; req_valid = v; req_addr = a;
    @(negedge clk);
  endtask

  // addresses packed {a3,a2,a1,a0}, 3 bits each
  localparam logic [11:0] A_ID  = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [11:0] A_R2  = {3'd0, 3'd5, 3'd0, 3'd0};
  localparam logic [11:0] A_R07 = {3'd3, 3'd2, 3'd1, 3'd7};

  initial begin
    int got;
    // reset state, then single request (addr2=5), idle cycles
    tv.push_back(mk(1, 4'b1111, A_ID, 4'b0000, 0, 0, 4'b0000, 8'h00));
    tv.push_back(mk(1, 4'b1111, A_ID, 4'b0000, 0, 0, 4'b0000, 8'h00));
    tv.push_back(mk(0, 4'b0100, A_R2, 4'b0100, 1, 5, 4'b0000, 8'h00));
    tv.push_back(mk(0, 4'b0000, A_R2, 4'b0000, 0, 0, 4'b0100, 8'h15));
    tv.push_back(mk(0, 4'b0000, A_R2, 4'b0000, 0, 0, 4'b0000, 8'h00));
`ifndef ROM_ARB_FIXED_PRIO_EN
    // all four requesting from reset: 0,1,2,3,0
    tv.push_back(mk(1, 4'b1111, A_ID, 4'b0000, 0, 0, 4'b0000, 8'h00));
    tv.push_back(mk(0, 4'b1111, A_ID, 4'b0001, 1, 0, 4'b0000, 8'h00));
    tv.push_back(mk(0, 4'b1111, A_ID, 4'b0010, 1, 1, 4'b0001, 8'h10));
    tv.push_back(mk(0, 4'b1111, A_ID, 4'b0100, 1, 2, 4'b0010, 8'h11));
    tv.push_back(mk(0, 4'b1111, A_ID, 4'b1000, 1, 3, 4'b0100, 8'h12));
    tv.push_back(mk(0, 4'b1111, A_ID, 4'b0001, 1, 0, 4'b1000, 8'h13));
    // requesters 1 and 3 alternate, pointer wraps after 3
    tv.push_back(mk(0, 4'b1010, A_ID, 4'b0010, 1, 1, 4'b0001, 8'h10));
    tv.push_back(mk(0, 4'b1010, A_ID, 4'b1000, 1, 3, 4'b0010, 8'h11));
    tv.push_back(mk(0, 4'b1010, A_ID, 4'b0010, 1, 1, 4'b1000, 8'h13));
    tv.push_back(mk(0, 4'b1010, A_ID, 4'b1000, 1, 3, 4'b0010, 8'h11));
    // idle: no grant, pointer stays 0
    tv.push_back(mk(0, 4'b0000, A_ID, 4'b0000, 0, 0, 4'b1000, 8'h13));
    // accept addr 7 for requester 0, reset next cycle squashes response
    tv.push_back(mk(0, 4'b0001, A_R07, 4'b0001, 1, 7, 4'b0000, 8'h00));
    tv.push_back(mk(1, 4'b0000, A_R07, 4'b0000, 0, 0, 4'b0000, 8'h00));
    tv.push_back(mk(0, 4'b1111, A_ID, 4'b0001, 1, 0, 4'b0000, 8'h00));
`else
    // fixed priority: lowest index always wins
    tv.push_back(mk(0, 4'b1111, A_ID, 4'b0001, 1, 0, 4'b0000, 8'h00));
    tv.push_back(mk(0, 4'b1111, A_ID, 4'b0001, 1, 0, 4'b0001, 8'h10));
    tv.push_back(mk(0, 4'b1111, A_ID, 4'b0001, 1, 0, 4'b0001, 8'h10));
    tv.push_back(mk(0, 4'b1111, A_ID, 4'b0001, 1, 0, 4'b0001, 8'h10));
    tv.push_back(mk(0, 4'b0001, A_R07, 4'b0001, 1, 7, 4'b0001, 8'h10));
    tv.push_back(mk(1, 4'b0000, A_R07, 4'b0000, 0, 0, 4'b0000, 8'h00));
    tv.push_back(mk(0, 4'b0110, A_ID, 4'b0010, 1, 1, 4'b0000, 8'h00));
`endif

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].vld, tv[i].addr);
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d rom_en", i),    32'(rom_en),    32'(tv[i].en));
      chk($sformatf("v%0d rom_addr", i),  32'(rom_addr),  32'(tv[i].raddr));
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(tv[i].rv));
      chk($sformatf("v%0d rsp_data", i),  32'(rsp_data),  32'(tv[i].rd));
    end

    // address only sampled on accept: change it the cycle after
    drive(0, 4'b1000, {3'd6, 3'd0, 3'd0, 3'd0});
    chk("samp req_ready", 32'(req_ready), 32'h8);
    chk("samp rom_addr",  32'(rom_addr),  32'd6);
    drive(0, 4'b0000, {3'd2, 3'd0, 3'd0, 3'd0});
    chk("samp rsp_valid", 32'(rsp_valid), 32'h8);
    chk("samp rsp_data",  32'(rsp_data),  32'h16);
    chk("samp rom_en",    32'(rom_en),    32'd0);

`ifndef ROM_ARB_FIXED_PRIO_EN
    // requester 2 holding valid among competitors is granted within NREQ cycles
    got = 0;
    for (int c = 0; c < NREQ && got == 0; c++) begin
      drive(0, 4'b1111, A_ID);
      if (req_ready[2]) got = 1;
    end
    chk("starve grant2", 32'(got), 32'd1);
`endif

    drive(1, 4'b0000, '0);
    chk("final rsp_valid", 32'(rsp_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
